// File: rtl/ser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ser_pkg
// Purpose  : Shared constants, FSM state type and helpers for the weight
//            serializer (weight_serializer / ser_shift_word).
// Contents : LENGTH, MAX_FEATURES, IDX_WIDTH - word and index geometry
//            SLOT      - bit cycles per transmitted word
//            CNT_WIDTH - width of the per-word bit counter
//            state_t   - serializer FSM states
//            clamp_feat() - limits a requested index to MAX_FEATURES
// Config   : WEIGHT_SER_PARITY_EN - when defined, each word carries a
//            trailing even-parity bit (SLOT = LENGTH + 1).
// Revision : 1.0 - initial release
// ============================================================================
package ser_pkg;

  localparam int LENGTH       = 16;
  localparam int MAX_FEATURES = 15;
  localparam int IDX_WIDTH    = 4;

`ifdef WEIGHT_SER_PARITY_EN
  localparam int SLOT = LENGTH + 1;
`else
  localparam int SLOT = LENGTH;
`endif

  localparam int CNT_WIDTH = $clog2(SLOT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Requests above the highest legal index are reduced to it.
  function automatic logic [IDX_WIDTH-1:0] clamp_feat(input logic [IDX_WIDTH-1:0] f);
    if (int'(f) > MAX_FEATURES) begin
      return IDX_WIDTH'(MAX_FEATURES);
    end
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ser_shift_word.sv
`default_nettype none
// ============================================================================
// Module   : ser_shift_word
// Purpose  : Datapath for one serialized word: shift register, prefetch
//            hold register, bit counter and (optionally) the parity bit.
//            Exposes counter-position strobes for the controlling FSM.
// Ports    : CLK      in   clock, rising edge
//            RST      in   synchronous active-low reset
//            load     in   load shift register from data_in, restart count
//            reload   in   load shift register from hold, restart count
//            shift    in   shift right one bit, advance count
//            capture  in   capture data_in into the hold register
//            data_in  in   [LENGTH] word from the weight store
//            bit_out  out  current frame bit (data LSB or parity)
//            pre_pt   out  count is one before the prefetch cycle
//            cap_pt   out  count is at the hold-capture cycle
//            last_bit out  count is at the final bit of the slot
// Config   : WEIGHT_SER_PARITY_EN adds the parity bit after the data bits.
// Revision : 1.0 - initial release
// ============================================================================
module ser_shift_word
  import ser_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic              reload,
  input  logic              shift,
  input  logic              capture,
  input  logic [LENGTH-1:0] data_in,
  output logic              bit_out,
  output logic              pre_pt,
  output logic              cap_pt,
  output logic              last_bit
);

  logic [LENGTH-1:0]    r_shreg;
  logic [LENGTH-1:0]    r_hold;
  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_shreg <= '0;
      r_hold  <= '0;
      r_cnt   <= '0;
    end else begin
      if (load) begin
        r_shreg <= data_in;
        r_cnt   <= '0;
      end else if (reload) begin
        r_shreg <= r_hold;
        r_cnt   <= '0;
      end else if (shift) begin
        r_shreg <= {1'b0, r_shreg[LENGTH-1:1]};
        r_cnt   <= r_cnt + 1'b1;
      end
      if (capture) begin
        r_hold <= data_in;
      end
    end
  end

  // The read port has one cycle of latency, so the request issued while the
  // count sits at SLOT-3 returns data during SLOT-2; the FSM registers its
  // request one cycle earlier, hence pre_pt at SLOT-4.
  assign pre_pt   = (r_cnt == CNT_WIDTH'(SLOT - 4));
  assign cap_pt   = (r_cnt == CNT_WIDTH'(SLOT - 2));
  assign last_bit = (r_cnt == CNT_WIDTH'(SLOT - 1));

`ifdef WEIGHT_SER_PARITY_EN
  logic r_par;

  // Parity is computed at load time so the slot's final cycle just selects it.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_par <= 1'b0;
    end else if (load) begin
      r_par <= ^data_in;
    end else if (reload) begin
      r_par <= ^r_hold;
    end
  end

  assign bit_out = (r_cnt == CNT_WIDTH'(LENGTH)) ? r_par : r_shreg[0];
`else
  assign bit_out = r_shreg[0];
`endif

endmodule
`default_nettype wire

// File: rtl/weight_serializer.sv
`default_nettype none
// ============================================================================
// Module   : weight_serializer
// Purpose  : Bit-serial transmitter for the trained weight vector. Reads
//            w[feat]..w[0] through a 1-cycle-latency read port and sends each
//            word LSB first on S_OUT, highest index first, with no gaps.
// Ports    : CLK      in   clock, rising edge
//            RST      in   synchronous active-low reset
//            start    in   one-cycle request, honoured only when idle
//            feat     in   [IDX_WIDTH] highest weight index to send
//            rd_en    out  read strobe to the weight store
//            rd_addr  out  [IDX_WIDTH] weight index to read (0 when idle)
//            rd_data  in   [LENGTH] weight word, valid cycle after rd_en
//            S_OUT    out  serial data bit (0 outside the frame)
//            S_VALID  out  S_OUT carries a frame bit
//            busy     out  high from accepted start until done
//            done     out  one-cycle pulse after the last bit
// Config   : WEIGHT_SER_PARITY_EN appends an even-parity bit to every word.
// Revision : 1.0 - initial release
// ============================================================================
module weight_serializer
  import ser_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [IDX_WIDTH-1:0] feat,
  output logic                 rd_en,
  output logic [IDX_WIDTH-1:0] rd_addr,
  input  logic [LENGTH-1:0]    rd_data,
  output logic                 S_OUT,
  output logic                 S_VALID,
  output logic                 busy,
  output logic                 done
);

  state_t               r_state;
  logic [IDX_WIDTH-1:0] r_idx;      // index of the most recently requested word
  logic                 r_pending;  // next word has been prefetched into hold

  logic w_load;
  logic w_reload;
  logic w_shift;
  logic w_capture;
  logic w_bit_out;
  logic w_pre_pt;
  logic w_cap_pt;
  logic w_last_bit;

  // FETCH spans two cycles: the read-issue cycle (rd_en high) and the data
  // cycle, where the first word is loaded straight from the read port.
  assign w_load    = (r_state == FETCH) && !rd_en;
  assign w_shift   = (r_state == SHIFT);
  assign w_reload  = (r_state == SHIFT) && w_last_bit && r_pending;
  assign w_capture = (r_state == SHIFT) && w_cap_pt && r_pending;

  ser_shift_word u_word (
    .CLK      (CLK),
    .RST      (RST),
    .load     (w_load),
    .reload   (w_reload),
    .shift    (w_shift),
    .capture  (w_capture),
    .data_in  (rd_data),
    .bit_out  (w_bit_out),
    .pre_pt   (w_pre_pt),
    .cap_pt   (w_cap_pt),
    .last_bit (w_last_bit)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_pending <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      S_VALID   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_idx     <= clamp_feat(feat);
            rd_en     <= 1'b1;
            rd_addr   <= clamp_feat(feat);
            busy      <= 1'b1;
            r_pending <= 1'b0;
            r_state   <= FETCH;
          end
        end

        FETCH: begin
          if (rd_en) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
          end else begin
            S_VALID <= 1'b1;
            r_state <= SHIFT;
          end
        end

        SHIFT: begin
          rd_en   <= 1'b0;
          rd_addr <= '0;
          // Request the next lower word early enough that it lands in hold
          // before the current slot ends, keeping the stream gap-free.
          if (w_pre_pt && (r_idx != '0)) begin
            rd_en     <= 1'b1;
            rd_addr   <= r_idx - 1'b1;
            r_idx     <= r_idx - 1'b1;
            r_pending <= 1'b1;
          end
          if (w_last_bit) begin
            if (r_pending) begin
              r_pending <= 1'b0;
            end else begin
              S_VALID <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= DONE;
            end
          end
        end

        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign S_OUT = S_VALID & w_bit_out;

endmodule
`default_nettype wire

// File: doc/weight_serializer.md
Name: weight_serializer

Overview:
- Bit-serial transmitter for the trained weight vector: the output-direction counterpart of the S serial loader on `main`.
- After SGD completes, reads weights w[feat]..w[0] from the weight register file through a 1-cycle-latency read port.
- Shifts them out on S_OUT in the same framing as the input stream: 16-bit words, highest index first, LSB first, contiguous bits with no gaps.
- Sits between the SGD core's weight storage and the board/testbench capture logic.

Parameters:
- LENGTH, 16, bits per word.
- MAX_FEATURES, 15, highest legal weight index.
- IDX_WIDTH, 4, width of feat and rd_addr; must satisfy 2**IDX_WIDTH > MAX_FEATURES.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- feat  input  IDX_WIDTH  highest weight index to send; latched on accepted start.
- rd_en  output  1  read strobe to the weight store.
- rd_addr  output  IDX_WIDTH  weight index to read.
- rd_data  input  LENGTH  weight word; valid the cycle after rd_en.
- S_OUT  output  1  serial data bit.
- S_VALID  output  1  high on every cycle that S_OUT carries a frame bit.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle pulse after the last bit.

Behaviour:
- Reset (RST=0 at an edge): state IDLE; all outputs 0; shift register, hold register, bit counter and index cleared. Reset applied mid-frame aborts the frame with no done pulse.
- States:
  - IDLE: start=1 → FETCH. Latch feat into f_q and idx=f_q. Drive rd_en=1, rd_addr=f_q. Set busy=1.
  - FETCH: one cycle, rd_data valid this cycle → SHIFT. Load shreg<=rd_data, cnt<=0, S_VALID<=1.
  - SHIFT: S_OUT = shreg[0] each cycle; shreg shifts right and cnt increments.
    - Prefetch when cnt==SLOT-3 and idx>0: rd_en=1, rd_addr=idx-1, idx decrements.
    - Capture rd_data into hold at the edge ending cnt==SLOT-2.
    - At the edge ending cnt==SLOT-1: if further words remain, shreg<=hold and cnt<=0; otherwise → DONE.
  - DONE: done=1, busy=0, S_VALID=0 for one cycle → IDLE.
- SLOT = LENGTH (LENGTH+1 with the optional feature).
- Latency: the first bit appears 2 cycles after the edge that samples start. The frame is exactly SLOT*(f_q+1) consecutive S_VALID cycles. Done is asserted in the cycle after the last bit.
- When S_VALID=0, S_OUT=0.
- start while busy: ignored, with no queuing.
- feat=0: one word is sent, with no prefetch.
- feat>MAX_FEATURES: clamped to MAX_FEATURES.
- rd_en is never asserted outside FETCH entry and the prefetch cycle; rd_addr is 0 when rd_en=0.
- feat changing after start has no effect.

Optional Feature:
- Macro WEIGHT_SER_PARITY_EN.
- Defined: each word is followed by one even-parity bit (XOR of the 16 data bits), giving SLOT=17. The prefetch point moves with SLOT, so the stream stays contiguous.
- Undefined: SLOT=16 and no parity logic is synthesized.

Decomposition:
- Package ser_pkg holds:
  - LENGTH and IDX_WIDTH constants;
  - state typedef {IDLE, FETCH, SHIFT, DONE};
  - SLOT localparam derived from the macro.
- One natural sub-module: ser_shift_word, containing the shift register, hold register, bit counter and parity bit, and exposing load/shift/last_bit strobes. The FSM and read-port control stay in the top.

Test Plan:
- Weight store w[i]=0x1000+i, feat=3, start pulse:
  - first S_OUT exactly 2 cycles after start;
  - 64 contiguous S_VALID cycles;
  - deserialized words 0x1003, 0x1002, 0x1001, 0x1000;
  - done pulses once, in the cycle after the last bit.
- feat=0, w[0]=0xA5C3: 16 bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; no prefetch rd_en issued; busy is high for 18 cycles.
- start re-pulsed at bit 7 of word 2 (feat=3): ignored; the frame is identical to scenario 1 and a single done is produced.
- RST=0 during bit 20 of a feat=2 frame: next cycle all outputs 0, no done; a subsequent start produces a full, clean frame.
- rd_en/rd_addr trace for feat=2: addr 2 at start+1, addr 1 at cnt 13 of word 0, addr 0 at cnt 13 of word 1; no other rd_en pulses.
- With WEIGHT_SER_PARITY_EN, w[0]=0x0007, feat=0: 17 bits, parity bit=1; frame length 17; for w[0]=0x0003 the parity bit is 0.
